// File: rtl/redirect_hazard_unit.sv
// rtl/redirect_hazard_unit.sv - load-use stall, branch flush and operand redirect sequencer (optional HAZ_STATS_EN counters)
module redirect_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwr,
    input  logic             id_load,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Shadow pipe: {v, rd, wr, ld} per stage
    logic             r_ex_v,  r_ex_wr,  r_ex_ld;
    logic             r_mem_v, r_mem_wr, r_mem_ld;
    logic             r_wb_v,  r_wb_wr,  r_wb_ld;
    logic [REG_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;

    logic w_ex_a, w_mem_a, w_wb_a;
    logic w_ex_b, w_mem_b, w_wb_b;
    logic w_load_use;
    logic w_stall;
    logic w_flush;
    logic w_bubble;
    logic [1:0] w_fwd_a, w_fwd_b;

    // Register 0 is hardwired, so it never takes a redirected value
    function automatic logic f_match(input logic v, input logic wr,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] r);
        return v && wr && (rd == r) && (r != '0);
    endfunction

    assign w_ex_a  = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  id_ra);
    assign w_mem_a = f_match(r_mem_v, r_mem_wr, r_mem_rd, id_ra);
    assign w_wb_a  = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  id_ra);
    assign w_ex_b  = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  id_rb);
    assign w_mem_b = f_match(r_mem_v, r_mem_wr, r_mem_rd, id_rb);
    assign w_wb_b  = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  id_rb);

    // Load data is only usable once the load has reached WB
    assign w_load_use = ((w_ex_a || w_ex_b) && r_ex_ld) ||
                        ((w_mem_a || w_mem_b) && r_mem_ld);

    // A taken branch makes the ID instruction wrong-path, so it wins over the stall
    assign w_flush  = br_taken && rst_n;
    assign w_stall  = w_load_use && id_valid && !br_taken && rst_n;
    assign w_bubble = w_flush || w_stall || !id_valid;

    // Redirect select: youngest non-load producer first, WB last
    always_comb begin
        w_fwd_a = SEL_RF;
        w_fwd_b = SEL_RF;
        if (id_valid && !w_stall) begin
            if (w_ex_a && !r_ex_ld)        w_fwd_a = SEL_EX;
            else if (w_mem_a && !r_mem_ld) w_fwd_a = SEL_MEM;
            else if (w_wb_a)               w_fwd_a = SEL_WB;

            if (w_ex_b && !r_ex_ld)        w_fwd_b = SEL_EX;
            else if (w_mem_b && !r_mem_ld) w_fwd_b = SEL_MEM;
            else if (w_wb_b)               w_fwd_b = SEL_WB;
        end
    end

    assign stall = w_stall;
    assign flush = w_flush;
    assign fwd_a = w_fwd_a;
    assign fwd_b = w_fwd_b;

    // Advance the shadow pipe; older stages always move on, EX takes ID or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v   <= 1'b0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_v  <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_ld <= 1'b0;
            r_mem_rd <= '0;
            r_wb_v   <= 1'b0;
            r_wb_wr  <= 1'b0;
            r_wb_ld  <= 1'b0;
            r_wb_rd  <= '0;
        end else begin
            r_wb_v   <= r_mem_v;
            r_wb_wr  <= r_mem_wr;
            r_wb_ld  <= r_mem_ld;
            r_wb_rd  <= r_mem_rd;
            r_mem_v  <= r_ex_v;
            r_mem_wr <= r_ex_wr;
            r_mem_ld <= r_ex_ld;
            r_mem_rd <= r_ex_rd;
            if (w_bubble) begin
                r_ex_v  <= 1'b0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
                r_ex_rd <= '0;
            end else begin
                r_ex_v  <= 1'b1;
                r_ex_wr <= id_regwr;
                r_ex_ld <= id_load;
                r_ex_rd <= id_rd;
            end
        end
    end

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_redirect_hazard_unit.sv
// tb/tb_redirect_hazard_unit.sv - directed vector bench for redirect_hazard_unit
module tb_redirect_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_ra, id_rb, id_rd;
    logic             id_regwr, id_load, br_taken;
    logic             stall, flush;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    redirect_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_ra     (id_ra),
        .id_rb     (id_rb),
        .id_rd     (id_rd),
        .id_regwr  (id_regwr),
        .id_load   (id_load),
        .br_taken  (br_taken),
        .stall     (stall),
        .flush     (flush),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;
    int exp_fc = 0;
    vec_t tbl [22];

    function automatic vec_t mk(input logic valid, input int ra, input int rb, input int rd,
                                input logic wr, input logic ld, input logic br,
                                input logic es, input logic ef, input int fa, input int fb);
        vec_t v;
        v.valid = valid; v.ra = 5'(ra); v.rb = 5'(rb); v.rd = 5'(rd);
        v.wr = wr; v.ld = ld; v.br = br;
        v.e_stall = es; v.e_flush = ef; v.e_fa = 2'(fa); v.e_fb = 2'(fb);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic es, input logic ef,
                              input logic [1:0] fa, input logic [1:0] fb);
        check({name, ".stall"}, int'(stall), int'(es));
        check({name, ".flush"}, int'(flush), int'(ef));
        check({name, ".fwd_a"}, int'(fwd_a), int'(fa));
        check({name, ".fwd_b"}, int'(fwd_b), int'(fb));
    endtask

    task automatic check_cnts(input string name);
`ifdef HAZ_STATS_EN
        check({name, ".stall_cnt"}, int'(stall_cnt), (exp_sc > CMAX) ? CMAX : exp_sc);
        check({name, ".flush_cnt"}, int'(flush_cnt), (exp_fc > CMAX) ? CMAX : exp_fc);
`else
        check({name, ".stall_cnt"}, int'(stall_cnt), 0);
        check({name, ".flush_cnt"}, int'(flush_cnt), 0);
`endif
    endtask

    // Drive one ID cycle away from the rising edge, check the combinational outputs
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        id_valid = v.valid; id_ra = v.ra; id_rb = v.rb; id_rd = v.rd;
        id_regwr = v.wr; id_load = v.ld; br_taken = v.br;
        #2;
        check_outs(name, v.e_stall, v.e_flush, v.e_fa, v.e_fb);
        if (v.e_stall) exp_sc++;
        if (v.e_flush) exp_fc++;
    endtask

    task automatic idle();
        @(negedge clk);
        id_valid = 1'b0; id_ra = '0; id_rb = '0; id_rd = '0;
        id_regwr = 1'b0; id_load = 1'b0; br_taken = 1'b0;
        #2;
    endtask

    initial begin
        //            vld ra  rb  rd  wr ld br  stl fl fa fb
        tbl[0]  = mk(1, 1,  2,  3,  1, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 3,  1,  5,  1, 0, 0,  0, 0, 1, 0);
        tbl[2]  = mk(1, 3,  0,  0,  0, 0, 0,  0, 0, 2, 0);
        tbl[3]  = mk(1, 3,  5,  0,  0, 0, 0,  0, 0, 3, 2);
        tbl[4]  = mk(1, 5,  3,  0,  0, 0, 0,  0, 0, 3, 0);
        tbl[5]  = mk(1, 1,  0,  4,  1, 1, 0,  0, 0, 0, 0);
        tbl[6]  = mk(1, 2,  4,  6,  1, 0, 0,  1, 0, 0, 0);
        tbl[7]  = mk(1, 2,  4,  6,  1, 0, 0,  1, 0, 0, 0);
        tbl[8]  = mk(1, 2,  4,  6,  1, 0, 0,  0, 0, 0, 3);
        tbl[9]  = mk(1, 0,  0,  0,  1, 1, 0,  0, 0, 0, 0);
        tbl[10] = mk(1, 0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
        tbl[11] = mk(1, 0,  0,  7,  1, 1, 0,  0, 0, 0, 0);
        tbl[12] = mk(1, 1,  2,  8,  1, 0, 0,  0, 0, 0, 0);
        tbl[13] = mk(1, 7,  8, 10,  1, 0, 0,  1, 0, 0, 0);
        tbl[14] = mk(1, 7,  8, 10,  1, 0, 0,  0, 0, 3, 2);
        tbl[15] = mk(1, 0,  0,  9,  1, 1, 0,  0, 0, 0, 0);
        tbl[16] = mk(1, 9, 10, 11,  1, 0, 1,  0, 1, 0, 2);
        tbl[17] = mk(1, 11, 10, 0,  0, 0, 0,  0, 0, 0, 3);
        tbl[18] = mk(0, 9,  0,  0,  0, 0, 0,  0, 0, 0, 0);
        tbl[19] = mk(1, 0,  0, 12,  1, 0, 0,  0, 0, 0, 0);
        tbl[20] = mk(1, 0,  0, 12,  1, 0, 0,  0, 0, 0, 0);
        tbl[21] = mk(1, 12, 12, 0,  0, 0, 0,  0, 0, 1, 1);

        rst_n = 1'b0;
        id_valid = 1'b1; id_ra = 5'd3; id_rb = 5'd3; id_rd = 5'd3;
        id_regwr = 1'b1; id_load = 1'b1; br_taken = 1'b1;
        #23;
        check_outs("reset", 1'b0, 1'b0, 2'b00, 2'b00);
        check_cnts("reset");
        idle();
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) apply(tbl[i], $sformatf("vec%0d", i));
        idle();
        check_cnts("after_table");

        // Reset in the first load-use stall cycle ends the stall at once
        apply(mk(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0), "rst_lw");
        apply(mk(1, 2, 4, 6, 1, 0, 0, 1, 0, 0, 0), "rst_stall");
        #1;
        rst_n = 1'b0;
        #1;
        exp_sc = 0;
        exp_fc = 0;
        check_outs("rst_mid", 1'b0, 1'b0, 2'b00, 2'b00);
        check_cnts("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

        // Ten load-use pairs give twenty stall cycles, enough to saturate a 4-bit counter
        for (int k = 0; k < 10; k++) begin
            apply(mk(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0), $sformatf("sat_lw%0d", k));
            apply(mk(1, 2, 4, 6, 1, 0, 0, 1, 0, 0, 0), $sformatf("sat_s1_%0d", k));
            apply(mk(1, 2, 4, 6, 1, 0, 0, 1, 0, 0, 0), $sformatf("sat_s2_%0d", k));
            apply(mk(1, 2, 4, 6, 1, 0, 0, 0, 0, 0, 3), $sformatf("sat_go%0d", k));
        end
        idle();
        check_cnts("saturate");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
